// File: rtl/multi_alarm_clock_pkg.sv
// Shared types and BCD bounds for the multi-channel alarm clock.
// Optional feature macro used by this design: ALARM_AUTO_TIMEOUT_EN.
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZED = 2'd2
    } chan_state_t;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } bcd_time_t;

    localparam logic [5:0] SEC_MAX         = 6'd59;
    localparam logic [1:0] HOUR1_MAX       = 2'd2;
    localparam logic [3:0] HOUR0_MAX_AT_20 = 4'd3;
    localparam logic [3:0] MIN1_MAX        = 4'd5;
    localparam logic [3:0] DIGIT_MAX       = 4'd9;

    // True when the digits form a legal hh:mm between 00:00 and 23:59.
    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic hour_ok;
        if (t.h1 < HOUR1_MAX)
            hour_ok = (t.h0 <= DIGIT_MAX);
        else
            hour_ok = (t.h1 == HOUR1_MAX) && (t.h0 <= HOUR0_MAX_AT_20);
        return hour_ok && (t.m1 <= MIN1_MAX) && (t.m0 <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/multi_alarm_clock_if.sv
// Control, digit and display bundle of the alarm clock; master drives controls.
interface multi_alarm_clock_if #(
    parameter int NUM_ALARMS = 4
);
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic                  load_time;
    logic                  load_alarm;
    logic [SEL_W-1:0]      alarm_sel;
    logic [1:0]            hour_in1;
    logic [3:0]            hour_in0;
    logic [3:0]            minute_in1;
    logic [3:0]            minute_in0;
    logic [NUM_ALARMS-1:0] alarm_enable;
    logic                  stop_alarm;
    logic                  snooze;
    logic [NUM_ALARMS-1:0] alarm;
    logic                  alarm_any;
    logic [1:0]            hour_out1;
    logic [3:0]            hour_out0;
    logic [3:0]            minute_out1;
    logic [3:0]            minute_out0;
    logic [5:0]            seconds;

    modport master (
        output load_time, load_alarm, alarm_sel, hour_in1, hour_in0,
               minute_in1, minute_in0, alarm_enable, stop_alarm, snooze,
        input  alarm, alarm_any, hour_out1, hour_out0, minute_out1,
               minute_out0, seconds
    );

    modport slave (
        input  load_time, load_alarm, alarm_sel, hour_in1, hour_in0,
               minute_in1, minute_in0, alarm_enable, stop_alarm, snooze,
        output alarm, alarm_any, hour_out1, hour_out0, minute_out1,
               minute_out0, seconds
    );

endinterface

// File: rtl/multi_alarm_clock_alarm_channel.sv
// One alarm channel: alarm register, IDLE/RINGING/SNOOZED FSM, snooze countdown.
// ALARM_AUTO_TIMEOUT_EN adds a ring counter that drops the channel after MAX_RING_SEC edges.
module alarm_channel
    import alarm_clock_pkg::*;
#(
    parameter int SNOOZE_MIN = 5
`ifdef ALARM_AUTO_TIMEOUT_EN
  , parameter int MAX_RING_SEC = 60
`endif
) (
    input  logic      clock_1s,
    input  logic      reset,
    input  logic      load,
    input  bcd_time_t load_value,
    input  logic      enable,
    input  logic      stop_alarm,
    input  logic      snooze,
    input  logic      match_tick,
    input  bcd_time_t time_nxt,
    output logic      ringing
);
    localparam int SNOOZE_SEC = SNOOZE_MIN * 60;
    localparam int SNZ_W      = $clog2(SNOOZE_SEC + 1);
    localparam logic [SNZ_W-1:0] SNOOZE_LOAD = SNZ_W'(SNOOZE_SEC - 1);

    chan_state_t      state_q, state_d;
    bcd_time_t        alarm_q, alarm_d;
    logic [SNZ_W-1:0] snz_q, snz_d;
    logic             match;

    // match_tick is low on load_time edges, so a loaded time never rings.
    assign match   = enable && match_tick && (time_nxt == alarm_q);
    assign ringing = (state_q == RINGING);

`ifdef ALARM_AUTO_TIMEOUT_EN
    localparam logic [7:0] RING_LAST = 8'(MAX_RING_SEC - 1);
    logic [7:0] ring_q, ring_d;

    // Counts edges spent in RINGING; any entry or exit restarts it at zero.
    always_comb begin
        ring_d = '0;
        if (state_q == RINGING && state_d == RINGING)
            ring_d = ring_q + 8'd1;
    end

    always_ff @(posedge clock_1s or posedge reset)
        if (reset) ring_q <= '0;
        else       ring_q <= ring_d;
`endif

    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        snz_d   = snz_q;
        if (load) begin
            state_d = IDLE;
            alarm_d = load_value;
            snz_d   = '0;
        end else if (!enable) begin
            state_d = IDLE;
        end else if (stop_alarm) begin
            state_d = IDLE;
        end else if (snooze && state_q == RINGING) begin
            state_d = SNOOZED;
            snz_d   = SNOOZE_LOAD;
        end else begin
            case (state_q)
                IDLE:    if (match) state_d = RINGING;
                RINGING: begin
`ifdef ALARM_AUTO_TIMEOUT_EN
                    if (ring_q == RING_LAST) state_d = IDLE;
`endif
                end
                SNOOZED: begin
                    if (match || snz_q == '0) state_d = RINGING;
                    else                      snz_d   = snz_q - 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock_1s or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            alarm_q <= '0;
            snz_q   <= '0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            snz_q   <= snz_d;
        end
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour BCD clock with NUM_ALARMS alarm channels driven by a 1 Hz tick.
// ALARM_AUTO_TIMEOUT_EN enables per-channel ring timeout after MAX_RING_SEC edges.
module multi_alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter int NUM_ALARMS   = 4,
    parameter int SNOOZE_MIN   = 5,
    parameter int MAX_RING_SEC = 60
) (
    input  logic                 clock_1s,
    input  logic                 reset,
    multi_alarm_clock_if.slave   bus
);
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    bcd_time_t             time_q, time_nxt, time_in;
    logic [5:0]            sec_q, sec_nxt;
    logic                  load_time_ok, load_alarm_ok, match_tick;
    logic [NUM_ALARMS-1:0] load_hit;
    logic [NUM_ALARMS-1:0] ringing;

    assign time_in       = {bus.hour_in1, bus.hour_in0, bus.minute_in1, bus.minute_in0};
    assign load_time_ok  = bus.load_time  && bcd_time_valid(time_in);
    assign load_alarm_ok = bus.load_alarm && bcd_time_valid(time_in);

    always_comb begin
        time_nxt = time_q;
        sec_nxt  = sec_q + 6'd1;
        if (load_time_ok) begin
            time_nxt = time_in;
            sec_nxt  = '0;
        end else if (sec_q == SEC_MAX) begin
            sec_nxt = '0;
            if (time_q.m0 != DIGIT_MAX) begin
                time_nxt.m0 = time_q.m0 + 4'd1;
            end else begin
                time_nxt.m0 = '0;
                if (time_q.m1 != MIN1_MAX) begin
                    time_nxt.m1 = time_q.m1 + 4'd1;
                end else begin
                    time_nxt.m1 = '0;
                    if (time_q.h1 == HOUR1_MAX && time_q.h0 == HOUR0_MAX_AT_20) begin
                        time_nxt.h1 = '0;
                        time_nxt.h0 = '0;
                    end else if (time_q.h0 == DIGIT_MAX) begin
                        time_nxt.h1 = time_q.h1 + 2'd1;
                        time_nxt.h0 = '0;
                    end else begin
                        time_nxt.h0 = time_q.h0 + 4'd1;
                    end
                end
            end
        end
    end

    // Channels compare against the value being written, so alarm and hh:mm:00 show together.
    assign match_tick = !load_time_ok && (sec_nxt == '0);

    always_comb begin
        load_hit = '0;
        for (int i = 0; i < NUM_ALARMS; i++)
            load_hit[i] = load_alarm_ok && (bus.alarm_sel == SEL_W'(i));
    end

    always_ff @(posedge clock_1s or posedge reset) begin
        if (reset) begin
            time_q <= '0;
            sec_q  <= '0;
        end else begin
            time_q <= time_nxt;
            sec_q  <= sec_nxt;
        end
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
        alarm_channel #(
            .SNOOZE_MIN   (SNOOZE_MIN)
`ifdef ALARM_AUTO_TIMEOUT_EN
          , .MAX_RING_SEC (MAX_RING_SEC)
`endif
        ) u_chan (
            .clock_1s   (clock_1s),
            .reset      (reset),
            .load       (load_hit[i]),
            .load_value (time_in),
            .enable     (bus.alarm_enable[i]),
            .stop_alarm (bus.stop_alarm),
            .snooze     (bus.snooze),
            .match_tick (match_tick),
            .time_nxt   (time_nxt),
            .ringing    (ringing[i])
        );
    end

    assign bus.alarm       = ringing;
    assign bus.alarm_any   = |ringing;
    assign bus.hour_out1   = time_q.h1;
    assign bus.hour_out0   = time_q.h0;
    assign bus.minute_out1 = time_q.m1;
    assign bus.minute_out0 = time_q.m0;
    assign bus.seconds     = sec_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed scoreboard bench for multi_alarm_clock; honours ALARM_AUTO_TIMEOUT_EN.
module tb_multi_alarm_clock;
    localparam int NUM_ALARMS   = 4;
    localparam int SNOOZE_MIN   = 1;
    localparam int MAX_RING_SEC = 10;

    logic clock_1s = 1'b0;
    logic reset    = 1'b1;

    multi_alarm_clock_if #(.NUM_ALARMS(NUM_ALARMS)) bus ();

    multi_alarm_clock #(
        .NUM_ALARMS   (NUM_ALARMS),
        .SNOOZE_MIN   (SNOOZE_MIN),
        .MAX_RING_SEC (MAX_RING_SEC)
    ) dut (
        .clock_1s (clock_1s),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 clock_1s = ~clock_1s;

    typedef struct {
        string       tag;
        logic [19:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   ms       = 0;   // model time of day in seconds

    function automatic logic [19:0] pack(input int t);
        int h, m, s;
        h = t / 3600;
        m = (t / 60) % 60;
        s = t % 60;
        return {2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 6'(s)};
    endfunction

    task automatic push(input string tag, input logic [19:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [19:0] obs);
        exp_t e;
        n_checks++;
        if (sb.size() == 0) begin
            n_fails++;
            $error("FAIL scoreboard_empty: observed %0h, expected an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fails++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic expect_state(input logic [3:0] alm);
        push("time", pack(ms));
        push("alarm", 20'(alm));
        push("alarm_any", 20'(|alm));
    endtask

    task automatic compare_outputs();
        pop_check({bus.hour_out1, bus.hour_out0, bus.minute_out1, bus.minute_out0, bus.seconds});
        pop_check(20'(bus.alarm));
        pop_check(20'(bus.alarm_any));
    endtask

    task automatic set_digits(input int h, input int m);
        bus.hour_in1   = 2'(h / 10);
        bus.hour_in0   = 4'(h % 10);
        bus.minute_in1 = 4'(m / 10);
        bus.minute_in0 = 4'(m % 10);
    endtask

    // One clock edge: predict the time, queue expectations, clock, compare, drop pulses.
    task automatic step(input logic [3:0] alm);
        int h, m;
        h = bus.hour_in1 * 10 + bus.hour_in0;
        m = bus.minute_in1 * 10 + bus.minute_in0;
        if (bus.load_time && bus.hour_in0 <= 9 && h <= 23 && bus.minute_in1 <= 5 && bus.minute_in0 <= 9)
            ms = (h * 60 + m) * 60;
        else
            ms = (ms + 1) % 86400;
        expect_state(alm);
        @(posedge clock_1s);
        #1;
        compare_outputs();
        bus.load_time  = 1'b0;
        bus.load_alarm = 1'b0;
        bus.stop_alarm = 1'b0;
        bus.snooze     = 1'b0;
    endtask

    initial begin
        bus.load_time    = 1'b0;
        bus.load_alarm   = 1'b0;
        bus.alarm_sel    = 2'd0;
        bus.alarm_enable = 4'b0000;
        bus.stop_alarm   = 1'b0;
        bus.snooze       = 1'b0;
        set_digits(0, 0);

        // Reset state, then first increment on the first edge after release.
        #2;
        expect_state(4'b0000);
        compare_outputs();
        #1 reset = 1'b0;
        step(4'b0000);

        // 23:59 load, rollover through 23:59:59 to 00:00:00.
        set_digits(23, 59);
        bus.load_time = 1'b1;
        step(4'b0000);
        repeat (60) step(4'b0000);

        // Alarm 0 at 07:30 with time loaded to 07:29.
        set_digits(7, 30);
        bus.load_alarm = 1'b1;
        bus.alarm_sel  = 2'd0;
        step(4'b0000);
        set_digits(7, 29);
        bus.load_time = 1'b1;
        step(4'b0000);
        bus.alarm_enable = 4'b0001;
        repeat (59) step(4'b0000);
        step(4'b0001);
        bus.stop_alarm = 1'b1;
        step(4'b0000);

        // Channel 1: ring, snooze for SNOOZE_MIN*60 edges, re-ring, stop.
        set_digits(7, 31);
        bus.load_alarm = 1'b1;
        bus.alarm_sel  = 2'd1;
        step(4'b0000);
        bus.alarm_enable = 4'b0011;
        repeat (57) step(4'b0000);
        step(4'b0010);
        bus.snooze = 1'b1;
        step(4'b0000);
        repeat (SNOOZE_MIN * 60 - 1) step(4'b0000);
        step(4'b0010);
        bus.stop_alarm = 1'b1;
        step(4'b0000);

        // Channel 2: stop and snooze together leave it idle with no re-ring.
        set_digits(7, 33);
        bus.load_alarm = 1'b1;
        bus.alarm_sel  = 2'd2;
        step(4'b0000);
        bus.alarm_enable = 4'b0111;
        repeat (56) step(4'b0000);
        step(4'b0100);
        bus.stop_alarm = 1'b1;
        bus.snooze     = 1'b1;
        step(4'b0000);
        repeat (SNOOZE_MIN * 60 + 1) step(4'b0000);

        // Invalid 25:61 load is ignored; time keeps counting.
        bus.hour_in1   = 2'd2;
        bus.hour_in0   = 4'd5;
        bus.minute_in1 = 4'd6;
        bus.minute_in0 = 4'd1;
        bus.load_time  = 1'b1;
        step(4'b0000);

        // Channel 3: reload while ringing silences it and stores the new time.
        set_digits(7, 35);
        bus.load_alarm = 1'b1;
        bus.alarm_sel  = 2'd3;
        step(4'b0000);
        bus.alarm_enable = 4'b1111;
        repeat (55) step(4'b0000);
        step(4'b1000);
        set_digits(7, 37);
        bus.load_alarm = 1'b1;
        bus.alarm_sel  = 2'd3;
        step(4'b0000);
        repeat (118) step(4'b0000);
        step(4'b1000);

`ifdef ALARM_AUTO_TIMEOUT_EN
        repeat (MAX_RING_SEC - 1) step(4'b1000);
        step(4'b0000);
`else
        repeat (100) step(4'b1000);
`endif

        // Asynchronous reset between edges clears time and alarms at once.
        #2 reset = 1'b1;
        #1;
        ms = 0;
        expect_state(4'b0000);
        compare_outputs();
        bus.alarm_enable = 4'b0000;
        #2 reset = 1'b0;
        step(4'b0000);
        step(4'b0000);

        if (sb.size() != 0) begin
            n_checks++;
            n_fails++;
            $error("FAIL scoreboard_leftover: observed %0d entries, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
